// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump streamer.
//   state_t      : frame sequencer states
//   HDR_DEFAULT  : default frame header byte
//   BYTE_W       : stream byte width
package reg_dump_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_SEND,
        ST_SUM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: walks a two-read-port register file pair by pair and streams
// its contents as a framed byte stream: header, registers big-endian in
// index order, then an XOR checksum of the register bytes.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : dump request, sampled only while idle
//   aaddr, baddr    : read addresses (even / odd register of current pair)
//   aout, bout      : read data, combinational from aaddr / baddr
//   tx_data/valid   : stream byte and valid
//   tx_ready        : downstream accept
//   busy            : frame in progress
//   done            : one-cycle pulse after the checksum byte is accepted
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = 2,
    parameter int unsigned DW   = 16,
    parameter logic [BYTE_W-1:0] HDR = HDR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [AW-1:0]       aaddr,
    output logic [AW-1:0]       baddr,
    input  logic [DW-1:0]       aout,
    input  logic [DW-1:0]       bout,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [AW-1:0] LAST_PAIR = AW'(NREG - 2);

    state_t              state;
    logic [2*DW-1:0]     pair_buf;
    logic [1:0]          byte_cnt;
    logic [BYTE_W-1:0]   csum;
    logic [BYTE_W-1:0]   next_byte;

    // Byte following the one currently on tx_data (byte 0 is loaded in ADDR).
    always_comb begin
        next_byte = '0;
        case (byte_cnt)
            2'd0:    next_byte = pair_buf[23:16];
            2'd1:    next_byte = pair_buf[15:8];
            default: next_byte = pair_buf[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            aaddr    <= '0;
            baddr    <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pair_buf <= '0;
            byte_cnt <= '0;
            csum     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_data  <= HDR;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        aaddr    <= '0;
                        baddr    <= AW'(1);
                        csum     <= '0;
                        state    <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // Both registers of the pair captured on the same edge.
                    pair_buf <= {aout, bout};
                    tx_data  <= aout[DW-1:DW-BYTE_W];
                    tx_valid <= 1'b1;
                    byte_cnt <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        csum <= csum ^ tx_data;
                        if (byte_cnt == 2'd3) begin
                            if (aaddr == LAST_PAIR) begin
                                // Running sum does not yet include the byte just accepted.
                                tx_data <= csum ^ tx_data;
                                state   <= ST_SUM;
                            end else begin
                                aaddr    <= aaddr + AW'(2);
                                baddr    <= baddr + AW'(2);
                                tx_valid <= 1'b0;
                                state    <= ST_ADDR;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            tx_data  <= next_byte;
                        end
                    end
                end
                ST_SUM: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  aaddr;
    logic [1:0]  baddr;
    logic [15:0] aout;
    logic [15:0] bout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [15:0] rf [4];

    assign aout = rf[aaddr];
    assign bout = rf[baddr];

    always #5 clk = ~clk;

    reg_dump #(.NREG(4), .AW(2), .DW(16), .HDR(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .aaddr    (aaddr),
        .baddr    (baddr),
        .aout     (aout),
        .bout     (bout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        logic [7:0] b;
        logic [1:0] a;
    } exp_t;

    exp_t q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   e0       = 0;
    bit   rand_ready = 1'b0;
    logic ready_val  = 1'b1;
    bit   hold_prev  = 1'b0;
    logic [7:0] hold_data = '0;
    bit   prev_done  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame from register values; pair index recorded for address checks.
    task automatic push_frame(input logic [15:0] r0, input logic [15:0] r1,
                              input logic [15:0] r2, input logic [15:0] r3);
        logic [15:0] v [4];
        logic [7:0]  cs;
        logic [7:0]  bt;
        v[0] = r0; v[1] = r1; v[2] = r2; v[3] = r3;
        cs = 8'h00;
        q.push_back('{b: 8'hA5, a: 2'd0});
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                bt = (k < 2) ? v[2*p][15 - 8*k -: 8] : v[2*p+1][15 - 8*(k-2) -: 8];
                cs = cs ^ bt;
                q.push_back('{b: bt, a: 2'(2*p)});
            end
        end
        q.push_back('{b: cs, a: 2'd2});
    endtask

    // One clock: drive ready, observe at negedge, cross the rising edge.
    task automatic step();
        exp_t e;
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        @(negedge clk);
        if (hold_prev) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
        end
        if (tx_valid && tx_ready && !rst) begin
            if (q.size() == 0) begin
                check("extra_byte", {24'd0, tx_data}, 32'h100);
            end else begin
                e = q.pop_front();
                check("byte", {24'd0, tx_data}, {24'd0, e.b});
                check("aaddr", {30'd0, aaddr}, {30'd0, e.a});
                check("baddr", {30'd0, baddr}, {30'd0, e.a} + 32'd1);
            end
        end
        hold_prev = tx_valid && !tx_ready && !rst;
        hold_data = tx_data;
        if (done && !rst) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", {31'd0, busy}, 32'd0);
            check("done_one_cycle", {31'd0, prev_done}, 32'd0);
        end
        prev_done = done;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_done(input int bound);
        int c0;
        c0 = done_cnt;
        for (int i = 0; i < bound && done_cnt == c0; i++) step();
        check("frame_done", done_cnt - c0, 32'd1);
    endtask

    task automatic set_regs(input logic [15:0] r2);
        rf[0] = 16'h1234; rf[1] = 16'hABCD; rf[2] = r2; rf[3] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        e0 = cyc;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        tx_ready = 1'b1;
        set_regs(16'h0000);
        repeat (3) step();
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_aaddr", {30'd0, aaddr}, 32'd0);
        check("rst_baddr", {30'd0, baddr}, 32'd0);
        check("rst_data",  {24'd0, tx_data}, 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // Basic frame, ready tied high: latency and content.
        push_frame(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
        pulse_start();
        check("hdr_valid", {31'd0, tx_valid}, 32'd1);
        check("hdr_busy",  {31'd0, busy}, 32'd1);
        check("hdr_data",  {24'd0, tx_data}, 32'hA5);
        wait_done(100);
        check("done_latency", done_cyc - e0, 32'd12);
        check("q_empty_1", q.size(), 32'd0);
        repeat (3) step();

        // Random backpressure.
        rand_ready = 1'b1;
        push_frame(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
        pulse_start();
        wait_done(400);
        check("q_empty_2", q.size(), 32'd0);
        rand_ready = 1'b0;
        ready_val = 1'b1;
        repeat (3) step();

        // start held high: two back-to-back frames, none extra.
        push_frame(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
        push_frame(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
        start = 1'b1;
        wait_done(100);
        check("idle_no_valid", {31'd0, tx_valid}, 32'd0);
        step();
        check("hdr2_valid", {31'd0, tx_valid}, 32'd1);
        check("hdr2_data",  {24'd0, tx_data}, 32'hA5);
        wait_done(100);
        start = 1'b0;
        repeat (6) step();
        check("q_empty_3", q.size(), 32'd0);
        check("no_third_frame", {31'd0, tx_valid}, 32'd0);

        // R2 rewritten while pair 0 is stalled.
        set_regs(16'h0000);
        push_frame(16'h1234, 16'hABCD, 16'h5555, 16'hFFFF);
        pulse_start();
        step();
        step();
        ready_val = 1'b0;
        repeat (4) step();
        check("stall_aaddr", {30'd0, aaddr}, 32'd0);
        check("stall_baddr", {30'd0, baddr}, 32'd1);
        rf[2] = 16'h5555;
        repeat (2) step();
        ready_val = 1'b1;
        wait_done(100);
        check("q_empty_4", q.size(), 32'd0);
        repeat (2) step();

        // Reset during the third data byte, then a clean frame.
        set_regs(16'h0000);
        push_frame(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
        pulse_start();
        repeat (4) step();
        check("third_byte", {24'd0, tx_data}, 32'hAB);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_aaddr", {30'd0, aaddr}, 32'd0);
        q.delete();
        step();
        push_frame(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
        pulse_start();
        check("post_rst_hdr", {24'd0, tx_data}, 32'hA5);
        wait_done(100);
        check("q_empty_5", q.size(), 32'd0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
